// File: rtl/rd_readout_ctrl.sv
// Sequences processor readout of one RD event buffer, clears its RD full flag and releases
// the WCD buffer. Define RD_CTRL_PARITY_SKIP_EN to discard parity-corrupt buffers unread.
module rd_readout_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned WRT_HOLD       = 4,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [1:0]  BUF_RNUM,
  input  logic [3:0]  RD_BUF_FULL,
  input  logic [3:0]  RD_BUF_BUSY,
  input  logic [3:0]  RD_PARITY_ERR,
  input  logic        XFER_DONE,
  output logic        RD_READY,
  output logic        RD_SKIP,
  output logic        RD_PERR,
  output logic [31:0] CONTROL,
  output logic        CONTROL_WRITTEN,
  output logic        WCD_RELEASE,
  output logic        DONE,
  output logic        BUSY,
  output logic [7:0]  TIMEOUT_COUNT,
  output logic [7:0]  START_OVERRUN
);
  localparam int unsigned HoldW = $clog2(WRT_HOLD + 1);
  localparam logic [CNT_W-1:0] CntLoad  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldLoad = HoldW'(WRT_HOLD - 1);

  typedef enum logic [2:0] {
    StIdle, StCheck, StWait, StAvail, StClear, StClrWait, StRelease
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       rnum_q, rnum_d, ctrl_q, ctrl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             wr_q, wr_d, perr_q, perr_d;
  logic [7:0]       tmo_q, tmo_d, ovr_q, ovr_d;
  logic             full_sel, busy_sel, perr_sel, found_full, tmo_hit, skip;

  assign full_sel = RD_BUF_FULL[rnum_q];
  assign busy_sel = RD_BUF_BUSY[rnum_q];
  assign perr_sel = RD_PARITY_ERR[rnum_q];

  always_comb begin
    state_d    = state_q;
    rnum_d     = rnum_q;
    ctrl_d     = ctrl_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    wr_d       = wr_q;
    perr_d     = perr_q;
    tmo_d      = tmo_q;
    ovr_d      = ovr_q;
    found_full = 1'b0;
    tmo_hit    = 1'b0;
    skip       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (START) begin
          rnum_d  = BUF_RNUM;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (full_sel) begin
          found_full = 1'b1;
        end else if (busy_sel) begin
          cnt_d   = CntLoad;
          state_d = StWait;
        end else begin
          skip    = 1'b1;
          state_d = StRelease;
        end
      end
      StWait: begin
        if (full_sel) begin
          found_full = 1'b1;
        end else if (!busy_sel) begin
          skip    = 1'b1;
          state_d = StRelease;
        end else if (cnt_q == '0) begin
          skip    = 1'b1;
          tmo_hit = 1'b1;
          state_d = StRelease;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StAvail: begin
        if (XFER_DONE) begin
          ctrl_d  = rnum_q;
          perr_d  = 1'b0;
          state_d = StClear;
        end
      end
      StClear: begin
        // First CLEAR cycle only presents CONTROL; the strobe follows one cycle later.
        if (!wr_q) begin
          wr_d   = 1'b1;
          hold_d = HoldLoad;
        end else if (hold_q == '0) begin
          wr_d    = 1'b0;
          cnt_d   = CntLoad;
          state_d = StClrWait;
        end else begin
          hold_d = hold_q - HoldW'(1);
        end
      end
      StClrWait: begin
        if (!full_sel) begin
          state_d = StRelease;
        end else if (cnt_q == '0) begin
          tmo_hit = 1'b1;
          state_d = StRelease;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase

    if (found_full) begin
`ifdef RD_CTRL_PARITY_SKIP_EN
      if (perr_sel) begin
        skip    = 1'b1;
        ctrl_d  = rnum_q;
        state_d = StClear;
      end else begin
        perr_d  = 1'b0;
        state_d = StAvail;
      end
`else
      perr_d  = perr_sel;
      state_d = StAvail;
`endif
    end

    if (tmo_hit && tmo_q != 8'hFF) begin
      tmo_d = tmo_q + 8'd1;
    end
    if (START && state_q != StIdle && ovr_q != 8'hFF) begin
      ovr_d = ovr_q + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      rnum_q  <= '0;
      ctrl_q  <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      wr_q    <= 1'b0;
      perr_q  <= 1'b0;
      tmo_q   <= '0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      rnum_q  <= rnum_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      wr_q    <= wr_d;
      perr_q  <= perr_d;
      tmo_q   <= tmo_d;
      ovr_q   <= ovr_d;
    end
  end

  assign RD_READY        = (state_q == StAvail);
  assign RD_SKIP         = skip;
  assign RD_PERR         = perr_q;
  assign CONTROL         = {30'd0, ctrl_q};
  assign CONTROL_WRITTEN = wr_q;
  assign WCD_RELEASE     = (state_q == StRelease);
  assign DONE            = (state_q == StRelease);
  assign BUSY            = (state_q != StIdle);
  assign TIMEOUT_COUNT   = tmo_q;
  assign START_OVERRUN   = ovr_q;
endmodule

// File: doc/rd_readout_ctrl.md
Name: rd_readout_ctrl

Overview:
- Sequences processor readout of Radio Detector (RD) event buffers after the WCD/SSD transfer.
- For the requested read buffer: checks the RD full/busy flags and waits a bounded time for an in-flight transfer.
- Then either hands the buffer to the processor or reports it absent.
- Finally clears the RD full flag through the RD control word and releases the WCD buffer.
- Lives in the AXI/processor clock domain, between the buffer manager and the RD serial interface.

Parameters:
TIMEOUT_CYCLES, 4096, max CLK cycles to wait for busy->full, and for full to clear after a control write
WRT_HOLD, 4, cycles CONTROL_WRITTEN is held high so the serial-clock-domain synchronizer catches it (min 2)
CNT_W, 16, width of the timeout down-counter (must hold TIMEOUT_CYCLES)

Ports:
CLK  in  1  system clock
RST  in  1  synchronous, active-high reset
START  in  1  1-cycle pulse: begin RD readout of buffer BUF_RNUM
BUF_RNUM  in  2  buffer number to read out, sampled with START
RD_BUF_FULL  in  4  per-buffer RD full flags (already synchronized to CLK)
RD_BUF_BUSY  in  4  per-buffer RD busy flags (already synchronized to CLK)
RD_PARITY_ERR  in  4  per-buffer OR of parity0/parity1 error flags
XFER_DONE  in  1  1-cycle pulse: processor has finished copying RD data
RD_READY  out  1  RD buffer valid, processor may read it
RD_SKIP  out  1  1-cycle pulse: no RD data for this event
RD_PERR  out  1  parity error flag for the buffer being read, valid while RD_READY
CONTROL  out  32  RD control word; bits[1:0] = buffer to clear, others 0
CONTROL_WRITTEN  out  1  control-write strobe, high for WRT_HOLD cycles
WCD_RELEASE  out  1  1-cycle pulse: reset WCD buffer full status for RNUM
DONE  out  1  1-cycle pulse, same cycle as WCD_RELEASE
BUSY  out  1  high whenever state != IDLE
TIMEOUT_COUNT  out  8  saturating count of wait timeouts (busy-wait or clear-wait)
START_OVERRUN  out  8  saturating count of START pulses ignored while BUSY

Behaviour:
- Reset: state IDLE; every output 0; internal RNUM, counters and hold counter 0.
- IDLE:
  - START: latch RNUM <= BUF_RNUM; go CHECK.
- CHECK (one cycle), evaluated on bit RNUM:
  - FULL=1 -> AVAIL.
  - else BUSY=1 -> load counter with TIMEOUT_CYCLES-1; go WAIT.
  - else -> pulse RD_SKIP; go RELEASE.
  - FULL has priority when FULL and BUSY are both set.
- WAIT:
  - FULL=1 -> AVAIL.
  - else BUSY=0 (busy dropped without full) -> RD_SKIP; go RELEASE.
  - else counter==0 -> RD_SKIP, TIMEOUT_COUNT+1; go RELEASE.
  - else decrement the counter.
  - Maximum dwell is TIMEOUT_CYCLES cycles.
- AVAIL:
  - RD_READY=1; RD_PERR = RD_PARITY_ERR[RNUM], latched on entry.
  - XFER_DONE -> RD_READY=0 next cycle; go CLEAR.
- CLEAR:
  - CONTROL[1:0]=RNUM is set on entry, one cycle before CONTROL_WRITTEN rises.
  - CONTROL_WRITTEN then stays high for exactly WRT_HOLD cycles.
  - After that: drop CONTROL_WRITTEN, load counter; go CLR_WAIT.
  - CONTROL holds its value until the next CLEAR.
- CLR_WAIT:
  - FULL[RNUM]=0 -> RELEASE.
  - counter==0 -> TIMEOUT_COUNT+1; go RELEASE.
- RELEASE (one cycle): WCD_RELEASE=1, DONE=1; go IDLE. Next START is accepted the cycle after.
- Every path goes through RELEASE, so the WCD buffer is always released.
- START with BUSY=1: ignored, START_OVERRUN+1.
- Both counters saturate at 255.
- XFER_DONE outside AVAIL is ignored.
- RST in any state, including mid-CONTROL_WRITTEN: next cycle IDLE with all outputs 0. No WCD_RELEASE is issued.

Optional Feature:
RD_CTRL_PARITY_SKIP_EN
- Defined: on entry to AVAIL with RD_PARITY_ERR[RNUM]=1, do not assert RD_READY. Instead pulse RD_SKIP and go directly to CLEAR, so the corrupt buffer is discarded and cleared. RD_PERR stays 0.
- Undefined: buffer is presented normally with RD_PERR=1.

Test Plan:
- Full buffer: FULL=4'b0100, START with BUF_RNUM=2 -> RD_READY 2 cycles after START. XFER_DONE -> CONTROL[1:0]=2, CONTROL_WRITTEN high 4 cycles. Drop FULL[2] -> WCD_RELEASE and DONE 1-cycle pulse, BUSY=0.
- Busy then full: BUSY[1]=1, FULL[1] set 100 cycles after START -> RD_READY, no RD_SKIP, TIMEOUT_COUNT=0.
- Busy timeout (TIMEOUT_CYCLES=16): BUSY[3] stuck -> RD_SKIP exactly 16 cycles after WAIT entry. Then WCD_RELEASE, TIMEOUT_COUNT=1, no CONTROL_WRITTEN.
- Empty buffer: FULL=BUSY=0, START BUF_RNUM=0 -> RD_SKIP on cycle 2, WCD_RELEASE on cycle 3.
- Overrun/reset: 3 START pulses while in AVAIL -> START_OVERRUN=3. RST during CONTROL_WRITTEN -> all outputs 0 next cycle, no WCD_RELEASE.
- Parity: RD_PARITY_ERR[2]=1, FULL[2]=1:
  - without macro -> RD_READY=1, RD_PERR=1.
  - with RD_CTRL_PARITY_SKIP_EN -> RD_SKIP pulse, RD_READY never set, CONTROL_WRITTEN asserted.
